// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4:1 TDM receive path.
package tdm_pkg;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  typedef enum logic {
    StIdle    = ST_IDLE,
    StCollect = ST_COLLECT
  } state_e;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam int unsigned NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_gap_timer.sv
// Idle-cycle watchdog for a frame in progress. Counts enabled cycles and raises
// expired combinationally on the GAP_MAX-th consecutive one; self-clears on expiry.
module tdm_gap_timer #(
  parameter int unsigned GAP_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(GAP_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(GAP_MAX - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = enable && (count_q == LAST);

  // Next count: clear on accept/expiry, otherwise advance on idle cycles.
  always_comb begin
    count_d = count_q;
    if (clear || expired) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM lane: steers slot words into shadow registers and
// publishes a complete a..d frame with a one-cycle strobe; flags aborted frames.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned GAP_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             frame_err
);

  state_e state_q, state_d;
  logic [1:0] sel_q, sel_d;
  // Slot 3 never needs a shadow: it is taken straight from din on completion.
  logic [NUM_SLOTS-2:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] ch_q, ch_d;
  logic fv_q, fv_d;
  logic fe_q, fe_d;

  logic gap_enable, gap_clear, gap_expired;

  tdm_gap_timer #(
    .GAP_MAX(GAP_MAX)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (gap_enable),
    .clear  (gap_clear),
    .expired(gap_expired)
  );

  // Frame FSM: slot steering, completion, restart and timeout handling.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    ch_d       = ch_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    gap_enable = 1'b0;
    gap_clear  = 1'b1;
    case (state_q)
      StIdle: begin
        if (din_valid && frame_start) begin
          shadow_d[SLOT_A] = din;
          sel_d            = SLOT_B;
          state_d          = StCollect;
        end
      end
      StCollect: begin
        gap_enable = !din_valid;
        gap_clear  = din_valid;
        if (din_valid) begin
          if (frame_start) begin
            // Early restart: drop the partial frame, this word is the new slot 0.
            fe_d             = 1'b1;
            shadow_d[SLOT_A] = din;
            sel_d            = SLOT_B;
          end else if (sel_q == SLOT_D) begin
            ch_d    = {din, shadow_q[SLOT_C], shadow_q[SLOT_B], shadow_q[SLOT_A]};
            fv_d    = 1'b1;
            sel_d   = SLOT_A;
            state_d = StIdle;
          end else begin
            if (sel_q == SLOT_B) begin
              shadow_d[SLOT_B] = din;
            end else begin
              shadow_d[SLOT_C] = din;
            end
            sel_d = sel_q + 2'd1;
          end
        end else if (gap_expired) begin
          fe_d    = 1'b1;
          sel_d   = SLOT_A;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = SLOT_A;
      end
    endcase
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= SLOT_A;
      shadow_q <= '0;
      ch_q     <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      ch_q     <= ch_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
    end
  end

  assign a           = ch_q[SLOT_A];
  assign b           = ch_q[SLOT_B];
  assign c           = ch_q[SLOT_C];
  assign d           = ch_q[SLOT_D];
  assign sel         = sel_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table, hand sequences for gap/timeout,
// then randomized traffic against a queue-based frame model.
module tb_tdm_demux4;

  localparam int unsigned GAP_MAX = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [0:0] a, b, c, d;
  logic [1:0] sel;
  logic       frame_valid, frame_err;

  int checks = 0;
  int failures = 0;

  tdm_demux4 #(
    .WIDTH  (1),
    .GAP_MAX(GAP_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .sel        (sel),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       dv;
    logic       fs;
    logic       din;
    logic       fv;
    logic       fe;
    logic [1:0] sel;
    logic [3:0] abcd;  // {a,b,c,d}
  } vec_t;

  vec_t vecs[$];

  // Reference model state: words of the frame in progress, idle run, last frame.
  logic       m_in_frame;
  logic       m_words[$];
  int         m_idle;
  logic [3:0] m_abcd;
  logic       m_fv, m_fe;

  task automatic add(input logic r, dv, fs, dn, fv, fe, input logic [1:0] s,
                     input logic [3:0] abcd);
    vec_t v;
    v.rst = r; v.dv = dv; v.fs = fs; v.din = dn;
    v.fv = fv; v.fe = fe; v.sel = s; v.abcd = abcd;
    vecs.push_back(v);
  endtask

  task automatic compare(input string nm, input logic fv, fe, input logic [1:0] s,
                         input logic [3:0] abcd);
    checks++;
    if ({a, b, c, d} !== abcd || sel !== s || frame_valid !== fv || frame_err !== fe) begin
      failures++;
      $display("FAIL %s @%0t: got abcd=%b sel=%0d fv=%b fe=%b, expected abcd=%b sel=%0d fv=%b fe=%b",
               nm, $time, {a, b, c, d}, sel, frame_valid, frame_err, abcd, s, fv, fe);
    end
  endtask

  // Drive one cycle, sample 1 time unit after the rising edge.
  task automatic step(input logic r, dv, fs, dn);
    rst = r; din_valid = dv; frame_start = fs; din = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic hand(input string nm, input logic dv, fs, dn, fv, fe,
                      input logic [1:0] s, input logic [3:0] abcd);
    step(1'b0, dv, fs, dn);
    compare(nm, fv, fe, s, abcd);
  endtask

  // Advance the model by one clock edge using the frame rules directly.
  task automatic model_step(input logic r, dv, fs, dn);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_in_frame = 1'b0; m_words.delete(); m_idle = 0; m_abcd = 4'b0000;
    end else if (!m_in_frame) begin
      if (dv && fs) begin
        m_words.delete(); m_words.push_back(dn); m_in_frame = 1'b1; m_idle = 0;
      end
    end else if (dv) begin
      m_idle = 0;
      if (fs) begin
        m_fe = 1'b1; m_words.delete(); m_words.push_back(dn);
      end else begin
        m_words.push_back(dn);
        if (m_words.size() == 4) begin
          m_abcd = {m_words[0], m_words[1], m_words[2], m_words[3]};
          m_fv = 1'b1; m_words.delete(); m_in_frame = 1'b0;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == GAP_MAX) begin
        m_fe = 1'b1; m_in_frame = 1'b0; m_words.delete(); m_idle = 0;
      end
    end
  endtask

  initial begin
    // Reset held with traffic present.
    add(1, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(1, 1, 0, 1, 0, 0, 0, 4'b0000);
    // Clean frame 1,0,1,1.
    add(0, 1, 1, 1, 0, 0, 1, 4'b0000);
    add(0, 1, 0, 0, 0, 0, 2, 4'b0000);
    add(0, 1, 0, 1, 0, 0, 3, 4'b0000);
    add(0, 1, 0, 1, 1, 0, 0, 4'b1011);
    add(0, 0, 0, 0, 0, 0, 0, 4'b1011);
    // Stray word in idle is ignored.
    add(0, 1, 0, 0, 0, 0, 0, 4'b1011);
    // Early restart on slot 2; restart word becomes a.
    add(0, 1, 1, 0, 0, 0, 1, 4'b1011);
    add(0, 1, 0, 1, 0, 0, 2, 4'b1011);
    add(0, 1, 1, 1, 0, 1, 1, 4'b1011);
    add(0, 1, 0, 1, 0, 0, 2, 4'b1011);
    add(0, 1, 0, 0, 0, 0, 3, 4'b1011);
    add(0, 1, 0, 0, 1, 0, 0, 4'b1100);
    // Three back-to-back frames: 0110, 1001, 0101.
    add(0, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, 1, 0, 1, 0, 0, 2, 4'b1100);
    add(0, 1, 0, 1, 0, 0, 3, 4'b1100);
    add(0, 1, 0, 0, 1, 0, 0, 4'b0110);
    add(0, 1, 1, 1, 0, 0, 1, 4'b0110);
    add(0, 1, 0, 0, 0, 0, 2, 4'b0110);
    add(0, 1, 0, 0, 0, 0, 3, 4'b0110);
    add(0, 1, 0, 1, 1, 0, 0, 4'b1001);
    add(0, 1, 1, 0, 0, 0, 1, 4'b1001);
    add(0, 1, 0, 1, 0, 0, 2, 4'b1001);
    add(0, 1, 0, 0, 0, 0, 3, 4'b1001);
    add(0, 1, 0, 1, 1, 0, 0, 4'b0101);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0101);
    // Reset mid-frame: partial frame dropped, no strobe.
    add(0, 1, 1, 1, 0, 0, 1, 4'b0101);
    add(0, 1, 0, 1, 0, 0, 2, 4'b0101);
    add(1, 1, 0, 1, 0, 0, 0, 4'b0000);
    add(0, 1, 0, 1, 0, 0, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].dv, vecs[i].fs, vecs[i].din);
      compare($sformatf("vec%0d", i), vecs[i].fv, vecs[i].fe, vecs[i].sel, vecs[i].abcd);
    end

    // Gapped frame: 3 idle cycles between slot 1 and slot 2.
    hand("gap_s0", 1, 1, 1, 0, 0, 1, 4'b0000);
    hand("gap_s1", 1, 0, 0, 0, 0, 2, 4'b0000);
    for (int i = 0; i < 3; i++) hand("gap_idle", 0, 0, 0, 0, 0, 2, 4'b0000);
    hand("gap_s2", 1, 0, 1, 0, 0, 3, 4'b0000);
    hand("gap_s3", 1, 0, 1, 1, 0, 0, 4'b1011);

    // Timeout after 2 slots: error on the 8th idle cycle, outputs kept.
    hand("to_s0", 1, 1, 0, 0, 0, 1, 4'b1011);
    hand("to_s1", 1, 0, 1, 0, 0, 2, 4'b1011);
    for (int i = 1; i < GAP_MAX; i++) hand("to_idle", 0, 0, 0, 0, 0, 2, 4'b1011);
    hand("to_expire", 0, 0, 0, 0, 1, 0, 4'b1011);
    hand("to_after", 0, 0, 0, 0, 0, 0, 4'b1011);

    // GAP_MAX-1 idle cycles are tolerated.
    hand("edge_s0", 1, 1, 0, 0, 0, 1, 4'b1011);
    for (int i = 1; i < GAP_MAX; i++) hand("edge_idle", 0, 0, 0, 0, 0, 1, 4'b1011);
    hand("edge_s1", 1, 0, 1, 0, 0, 2, 4'b1011);
    hand("edge_s2", 1, 0, 1, 0, 0, 3, 4'b1011);
    hand("edge_s3", 1, 0, 0, 1, 0, 0, 4'b0110);

    // Randomized traffic against the model, starting from a reset.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    compare("rand_reset", m_fv, m_fe, 2'd0, m_abcd);
    for (int i = 0; i < 4000; i++) begin
      logic r, dv, fs, dn;
      int burst;
      burst = 0;
      if ($urandom_range(0, 99) == 0) burst = $urandom_range(GAP_MAX - 2, GAP_MAX + 2);
      r  = ($urandom_range(0, 299) == 0);
      dv = (burst == 0) && ($urandom_range(0, 99) < 65);
      fs = ($urandom_range(0, 99) < 22);
      dn = 1'($urandom_range(0, 1));
      step(r, dv, fs, dn);
      model_step(r, dv, fs, dn);
      compare("rand", m_fv, m_fe, m_in_frame ? 2'(m_words.size()) : 2'd0, m_abcd);
      for (int j = 0; j < burst; j++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        compare("rand_idle", m_fv, m_fe, m_in_frame ? 2'(m_words.size()) : 2'd0, m_abcd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
